// File: rtl/prog_loader_host.sv
// Host side of the CPU program-load / console link: streams sync, word count and ROM words, waits for the ack, then bridges console bytes.
// Optional ACK_WAIT timeout is enabled by defining PROG_LOADER_TIMEOUT_EN.

module uart_tx #(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] sdata,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       txd
);
    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int CW      = $clog2(BIT_CYC);

    logic [CW-1:0] cnt_r;
    logic [3:0]    bit_r;
    logic [8:0]    frame_r;
    logic          busy_r;
    logic          txd_r;

    // 8N1 serializer; busy stays high through the whole stop bit
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_r   <= {CW{1'b0}};
            bit_r   <= 4'd0;
            frame_r <= 9'h1FF;
            busy_r  <= 1'b0;
            txd_r   <= 1'b1;
        end else if (!busy_r) begin
            cnt_r <= {CW{1'b0}};
            bit_r <= 4'd0;
            if (tx_start) begin
                busy_r  <= 1'b1;
                txd_r   <= 1'b0;
                frame_r <= {1'b1, sdata};
            end else begin
                txd_r <= 1'b1;
            end
        end else if (cnt_r == CW'(BIT_CYC - 1)) begin
            cnt_r <= {CW{1'b0}};
            if (bit_r == 4'd9) begin
                busy_r <= 1'b0;
                txd_r  <= 1'b1;
            end else begin
                txd_r   <= frame_r[0];
                frame_r <= {1'b1, frame_r[8:1]};
                bit_r   <= bit_r + 4'd1;
            end
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign tx_busy = busy_r;
    assign txd     = txd_r;
endmodule

module uart_rx #(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rx_ready,
    output logic       ferr
);
    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int CW      = $clog2(BIT_CYC);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3} rx_state_t;

    rx_state_t     st_r;
    logic [1:0]    sync_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_r;
    logic [7:0]    data_r;
    logic [7:0]    rdata_r;
    logic          ready_r;
    logic          ferr_r;

    // Mid-bit sampling deserializer; a start bit that is high at its midpoint is treated as a glitch
    always_ff @(posedge clk) begin
        if (!rstn) begin
            st_r    <= R_IDLE;
            sync_r  <= 2'b11;
            cnt_r   <= {CW{1'b0}};
            bit_r   <= 3'd0;
            data_r  <= 8'h00;
            rdata_r <= 8'h00;
            ready_r <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], rxd};
            ready_r <= 1'b0;
            case (st_r)
                R_IDLE: begin
                    cnt_r <= {CW{1'b0}};
                    if (!sync_r[1]) st_r <= R_START;
                end
                R_START: begin
                    if (cnt_r == CW'(CLK_PER_HALF_BIT - 1)) begin
                        cnt_r <= {CW{1'b0}};
                        bit_r <= 3'd0;
                        st_r  <= sync_r[1] ? R_IDLE : R_DATA;
                    end else begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                R_DATA: begin
                    if (cnt_r == CW'(BIT_CYC - 1)) begin
                        cnt_r  <= {CW{1'b0}};
                        data_r <= {sync_r[1], data_r[7:1]};
                        bit_r  <= bit_r + 3'd1;
                        if (bit_r == 3'd7) st_r <= R_STOP;
                    end else begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                R_STOP: begin
                    if (cnt_r == CW'(BIT_CYC - 1)) begin
                        cnt_r   <= {CW{1'b0}};
                        rdata_r <= data_r;
                        ferr_r  <= ~sync_r[1];
                        ready_r <= 1'b1;
                        st_r    <= R_IDLE;
                    end else begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: st_r <= R_IDLE;
            endcase
        end
    end

    assign rdata    = rdata_r;
    assign rx_ready = ready_r;
    assign ferr     = ferr_r;
endmodule

module prog_loader_host #(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int INST_SIZE        = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [INST_SIZE:0]   word_count,
    output logic [INST_SIZE-1:0] rom_addr,
    input  logic [31:0]          rom_data,
    output logic                 txd,
    input  logic                 rxd,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           out_byte,
    output logic                 out_valid
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_SYNC = 3'd1, S_CNT = 3'd2, S_FETCH = 3'd3,
        S_WORD = 3'd4, S_ACK_WAIT = 3'd5, S_RUN = 3'd6, S_ERR = 3'd7
    } state_t;

    state_t               state_r;
    logic [INST_SIZE:0]   n_r;
    logic [INST_SIZE-1:0] idx_r;
    logic [INST_SIZE-1:0] rom_addr_r;
    logic [31:0]          shift_r;
    logic [1:0]           byte_cnt_r;
    logic                 fetch_wait_r;
    logic                 tx_start_r;
    logic [7:0]           tx_data_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;
    logic [7:0]           out_byte_r;
    logic                 out_valid_r;
    logic                 rstn_s;
    logic                 tx_busy_s;
    logic                 rx_ready_s;
    logic                 ferr_s;
    logic [7:0]           rx_data_s;
    logic                 can_issue_s;
    logic                 last_word_s;
    logic                 to_hit_s;

    assign rstn_s = ~rst;

    // tx_busy only rises the cycle after tx_start, so the cycle right after an issue is blocked too
    assign can_issue_s = !tx_busy_s && !tx_start_r;
    assign last_word_s = ({1'b0, idx_r} + {{INST_SIZE{1'b0}}, 1'b1}) >= n_r;

`ifdef PROG_LOADER_TIMEOUT_EN
    logic [31:0] to_cnt_r;

    // Ack timeout counter, held at zero outside ACK_WAIT so it restarts on every entry
    always_ff @(posedge clk) begin
        if (rst || (state_r != S_ACK_WAIT)) begin
            to_cnt_r <= 32'd0;
        end else begin
            to_cnt_r <= to_cnt_r + 32'd1;
        end
    end

    assign to_hit_s = (to_cnt_r == 32'h00FF_FFFF);
`else
    assign to_hit_s = 1'b0;
`endif

    // Load / console state machine with registered status, ROM address and console outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            n_r          <= {(INST_SIZE+1){1'b0}};
            idx_r        <= {INST_SIZE{1'b0}};
            rom_addr_r   <= {INST_SIZE{1'b0}};
            shift_r      <= 32'd0;
            byte_cnt_r   <= 2'd0;
            fetch_wait_r <= 1'b0;
            tx_start_r   <= 1'b0;
            tx_data_r    <= 8'h00;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            out_byte_r   <= 8'h00;
            out_valid_r  <= 1'b0;
        end else begin
            tx_start_r  <= 1'b0;
            out_valid_r <= 1'b0;
            case (state_r)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        n_r     <= word_count;
                        idx_r   <= {INST_SIZE{1'b0}};
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        err_r   <= 1'b0;
                        state_r <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (can_issue_s) begin
                        tx_start_r <= 1'b1;
                        tx_data_r  <= 8'hAA;
                        shift_r    <= 32'(n_r);
                        byte_cnt_r <= 2'd0;
                        state_r    <= S_CNT;
                    end
                end
                S_CNT, S_WORD: begin
                    if (can_issue_s) begin
                        tx_start_r <= 1'b1;
                        tx_data_r  <= shift_r[31:24];
                        shift_r    <= {shift_r[23:0], 8'h00};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            fetch_wait_r <= 1'b0;
                            if (state_r == S_CNT) begin
                                if (n_r == {(INST_SIZE+1){1'b0}}) begin
                                    state_r <= S_ACK_WAIT;
                                end else begin
                                    rom_addr_r <= {INST_SIZE{1'b0}};
                                    state_r    <= S_FETCH;
                                end
                            end else if (last_word_s) begin
                                state_r <= S_ACK_WAIT;
                            end else begin
                                idx_r      <= idx_r + {{(INST_SIZE-1){1'b0}}, 1'b1};
                                rom_addr_r <= idx_r + {{(INST_SIZE-1){1'b0}}, 1'b1};
                                state_r    <= S_FETCH;
                            end
                        end
                    end
                end
                S_FETCH: begin
                    // One settle cycle so the synchronous ROM has presented data for the new address
                    if (!fetch_wait_r) begin
                        fetch_wait_r <= 1'b1;
                    end else begin
                        shift_r    <= rom_data;
                        byte_cnt_r <= 2'd0;
                        state_r    <= S_WORD;
                    end
                end
                S_ACK_WAIT: begin
                    if (rx_ready_s) begin
                        busy_r <= 1'b0;
                        if ((rx_data_s == 8'hAA) && !ferr_s) begin
                            done_r  <= 1'b1;
                            state_r <= S_RUN;
                        end else begin
                            err_r   <= 1'b1;
                            state_r <= S_ERR;
                        end
                    end else if (to_hit_s) begin
                        busy_r  <= 1'b0;
                        err_r   <= 1'b1;
                        state_r <= S_ERR;
                    end
                end
                S_RUN: begin
                    if (in_valid && can_issue_s) begin
                        tx_start_r <= 1'b1;
                        tx_data_r  <= in_byte;
                    end
                    if (rx_ready_s && !ferr_s) begin
                        out_byte_r  <= rx_data_s;
                        out_valid_r <= 1'b1;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    uart_tx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_tx (
        .clk      (clk),
        .rstn     (rstn_s),
        .sdata    (tx_data_r),
        .tx_start (tx_start_r),
        .tx_busy  (tx_busy_s),
        .txd      (txd)
    );

    uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
        .clk      (clk),
        .rstn     (rstn_s),
        .rxd      (rxd),
        .rdata    (rx_data_s),
        .rx_ready (rx_ready_s),
        .ferr     (ferr_s)
    );

    assign rom_addr  = rom_addr_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign in_ready  = (state_r == S_RUN) && can_issue_s;
    assign out_byte  = out_byte_r;
    assign out_valid = out_valid_r;
endmodule

// File: tb/tb_prog_loader_host.sv
// Scoreboard bench for prog_loader_host: decodes txd against expected bytes, drives rxd, checks console delivery.
module tb_prog_loader_host;
    localparam int HB  = 4;
    localparam int BIT = 2 * HB;
    localparam int IS  = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [IS:0]   word_count = '0;
    logic [IS-1:0] rom_addr;
    logic [31:0]   rom_data = 32'd0;
    logic          txd;
    logic          rxd = 1'b1;
    logic          busy, done, err;
    logic [7:0]    in_byte = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    out_byte;
    logic          out_valid;

    int n_checks = 0;
    int n_fail = 0;
    int rst_cycles = 0;
    int out_cnt = 0;
    int busy_low = 0;
    int rom_max = 0;
    logic [7:0]  tx_exp[$];
    logic [7:0]  rx_exp[$];
    logic [31:0] rom_img [2] = '{32'h20010005, 32'hFC200000};

    always #5 clk = ~clk;

    prog_loader_host #(.CLK_PER_HALF_BIT(HB), .INST_SIZE(IS)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .rom_addr(rom_addr), .rom_data(rom_data), .txd(txd), .rxd(rxd),
        .busy(busy), .done(done), .err(err),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .out_byte(out_byte), .out_valid(out_valid)
    );

    // synchronous program ROM
    always @(posedge clk) rom_data <= (rom_addr < 15'd2) ? rom_img[rom_addr[0]] : 32'd0;

    always @(posedge clk) if (rst) rst_cycles <= rst_cycles + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // txd decoder: frames cut by a reset are dropped
    initial begin : tx_mon
        logic [7:0] b;
        int r0;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                r0 = rst_cycles;
                repeat (HB) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BIT) @(negedge clk);
                if (rst_cycles == r0) begin
                    check_eq("tx_stop_bit", 32'(txd), 32'd1);
                    if (tx_exp.size() == 0) check_eq("tx_unexpected_frame", 32'(b), 32'hFFFF_FFFF);
                    else check_eq("tx_byte", 32'(b), 32'(tx_exp.pop_front()));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid) begin
            out_cnt <= out_cnt + 1;
            if (rx_exp.size() == 0) check_eq("out_unexpected", 32'(out_byte), 32'hFFFF_FFFF);
            else check_eq("out_byte", 32'(out_byte), 32'(rx_exp.pop_front()));
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_rx(input logic [7:0] b);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        word_count = 16'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_load(input int n);
        logic [31:0] w;
        tx_exp.push_back(8'hAA);
        w = 32'(n);
        for (int i = 3; i >= 0; i--) tx_exp.push_back(w[i*8 +: 8]);
        for (int k = 0; k < n; k++) begin
            w = rom_img[k];
            for (int i = 3; i >= 0; i--) tx_exp.push_back(w[i*8 +: 8]);
        end
    endtask

    task automatic wait_drain(input int budget, input bit early, input string tag);
        bit forked = 1'b0;
        int c = 0;
        while (tx_exp.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
            if (!busy) busy_low++;
            if (int'(rom_addr) > rom_max) rom_max = int'(rom_addr);
            if (early && !forked && tx_exp.size() == 6) begin
                forked = 1'b1;
                fork
                    send_rx(8'hAA);
                join_none
            end
        end
        check_eq(tag, 32'(tx_exp.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
        check_eq({pfx, "_done"}, 32'(done), 32'd0);
        check_eq({pfx, "_err"}, 32'(err), 32'd0);
        check_eq({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
        check_eq({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({pfx, "_out_byte"}, 32'(out_byte), 32'd0);
        check_eq({pfx, "_txd"}, 32'(txd), 32'd1);
    endtask

    initial begin : stim
        int acc;
        int hi;
        int c;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // two-word load with an early 0xAA injected while words are being sent
        expect_load(2);
        busy_low = 0;
        rom_max = 0;
        do_start(2);
        wait_drain(2000, 1'b1, "load1_drain");
        check_eq("load1_busy_low", 32'(busy_low), 32'd0);
        check_eq("load1_rom_max", 32'(rom_max), 32'd1);
        check_eq("load1_rom_addr", 32'(rom_addr), 32'd1);
        check_eq("ackwait_done", 32'(done), 32'd0);
        check_eq("ackwait_busy", 32'(busy), 32'd1);
        send_rx(8'hAA);
        repeat (4) @(negedge clk);
        check_eq("run_done", 32'(done), 32'd1);
        check_eq("run_busy", 32'(busy), 32'd0);
        check_eq("run_err", 32'(err), 32'd0);
        check_eq("ack_not_delivered", 32'(out_cnt), 32'd0);

        // console output
        rx_exp.push_back(8'h41);
        send_rx(8'h41);
        repeat (4) @(negedge clk);
        check_eq("out_count", 32'(out_cnt), 32'd1);
        check_eq("out_queue", 32'(rx_exp.size()), 32'd0);

        // console input held valid for three cycles
        check_eq("run_in_ready", 32'(in_ready), 32'd1);
        tx_exp.push_back(8'h37);
        in_byte = 8'h37;
        in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("in_accept_count", 32'(acc), 32'd1);
        hi = 0;
        repeat (60) begin
            @(negedge clk);
            if (in_ready) hi++;
        end
        check_eq("in_ready_while_busy", 32'(hi), 32'd0);
        wait_drain(300, 1'b0, "in_drain");
        c = 0;
        while (!in_ready && c < 40) begin
            @(negedge clk);
            c++;
        end
        check_eq("in_ready_after_frame", 32'(in_ready), 32'd1);

        // start is ignored in RUN
        do_start(2);
        repeat (120) @(negedge clk);
        check_eq("run_start_ignored_done", 32'(done), 32'd1);
        check_eq("run_start_ignored_busy", 32'(busy), 32'd0);

        // reset out of RUN, then reset in the middle of a count byte
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_run");
        repeat (3) @(negedge clk);
        expect_load(2);
        do_start(2);
        c = 0;
        while (tx_exp.size() > 11 && c < 400) begin
            @(negedge clk);
            c++;
        end
        repeat (30) @(negedge clk);
        tx_exp.delete();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_cnt");
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check_eq("post_rst_txd", 32'(txd), 32'd1);

        // empty program, bad ack, then restart from ERR
        expect_load(0);
        busy_low = 0;
        rom_max = 0;
        do_start(0);
        wait_drain(800, 1'b0, "n0_drain");
        check_eq("n0_rom_max", 32'(rom_max), 32'd0);
        check_eq("n0_busy", 32'(busy), 32'd1);
        send_rx(8'h55);
        repeat (4) @(negedge clk);
        check_eq("bad_ack_err", 32'(err), 32'd1);
        check_eq("bad_ack_done", 32'(done), 32'd0);
        check_eq("bad_ack_busy", 32'(busy), 32'd0);
        check_eq("bad_ack_no_out", 32'(out_cnt), 32'd1);
        expect_load(1);
        do_start(1);
        wait_drain(1500, 1'b0, "restart_drain");
        check_eq("restart_busy", 32'(busy), 32'd1);
        check_eq("restart_err", 32'(err), 32'd0);
        send_rx(8'hAA);
        repeat (4) @(negedge clk);
        check_eq("restart_done", 32'(done), 32'd1);
        repeat (100) @(negedge clk);
        check_eq("final_tx_queue", 32'(tx_exp.size()), 32'd0);
        check_eq("final_rx_queue", 32'(rx_exp.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
